pcf8563_poll_sched: RTL and testbench

- Scheduler and controller for the single PCF8563 byte-read engine, whose handshake is `start`/`done`/`rdata`.
- Issues periodic time-read transactions and merges on-demand software requests onto that one engine.
- Collects the 7 returned time bytes (seconds..years), masks the non-time bits, and publishes an atomic time snapshot to the APDAQ subsystem.
- Detects a stalled engine with a per-byte timeout.

---
 rtl/pcf8563_poll_sched.sv | 178 +++++++++++++++++
 tb/tb_pcf8563_poll_sched.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcf8563_poll_sched.sv
// PCF8563 poll scheduler: arbitrates periodic and software-requested time reads
// onto one byte-read engine, gathers the seven time bytes and publishes an
// atomic, masked snapshot. A per-byte timeout aborts a stalled engine.
module pcf8563_poll_sched #(
   parameter int PERIOD  = 100000000,
   parameter int TIMEOUT = 2000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       req,
   output logic       if_start,
   input  logic [7:0] if_rdata,
   input  logic       if_done,
   output logic [6:0] sec,
   output logic [6:0] min,
   output logic [5:0] hour,
   output logic [5:0] day,
   output logic [2:0] wday,
   output logic [4:0] month,
   output logic [7:0] year,
   output logic       vl,
   output logic       century,
   output logic       snap_valid,
   output logic       busy,
   output logic       timeout_err
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] PMAX  = PW'(PERIOD - 1);
   localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      COLLECT = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [2:0]    idx;
   logic          pend;
   logic [7:0]    shadow [0:5];

   logic tick;
   logic launch;
   logic capture;
   logic commit;
   logic expire;

   assign tick = (pcnt == PMAX);

   // Next-state and handshake decode; en low in any busy state aborts to IDLE.
   always_comb begin
      state_nxt = state;
      if_start  = 1'b0;
      busy      = 1'b0;
      launch    = 1'b0;
      capture   = 1'b0;
      commit    = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (en && (pend || tick)) begin
               state_nxt = START;
               launch    = 1'b1;
            end
         end
         START: begin
            busy      = 1'b1;
            if_start  = en;
            state_nxt = en ? COLLECT : IDLE;
         end
         COLLECT: begin
            busy = 1'b1;
            if (!en) begin
               state_nxt = IDLE;
            end else if (if_done) begin
               // A done on the last allowed cycle still counts as a byte.
               capture = 1'b1;
               if (idx == 3'd6) begin
                  commit    = 1'b1;
                  state_nxt = COMMIT;
               end
            end else if (tcnt == TW'(1)) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         COMMIT: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Poll period counter: runs only while idle and enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                pcnt <= '0;
      else if (!en || launch)    pcnt <= '0;
      else if (state == IDLE)    pcnt <= pcnt + PW'(1);
   end

   // Per-byte watchdog: reloaded at launch and on every returned byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          tcnt <= '0;
      else if (state == START || capture)  tcnt <= TLOAD;
      else if (state == COLLECT)           tcnt <= tcnt - TW'(1);
   end

   // Byte index within the current transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              idx <= '0;
      else if (state == START) idx <= '0;
      else if (capture)        idx <= idx + 3'd1;
   end

   // Pending software request; a req coinciding with launch is served by it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pend <= 1'b0;
      else if (launch) pend <= 1'b0;
      else if (req)    pend <= 1'b1;
   end

   // Shadow bytes 0..5; byte 6 is taken straight from the bus at commit.
   always_ff @(posedge clk) begin
      if (capture && !commit) shadow[idx] <= if_rdata;
   end

   // Snapshot loads on the edge entering COMMIT so data and snap_valid align.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec     <= '0;
         vl      <= 1'b0;
         min     <= '0;
         hour    <= '0;
         day     <= '0;
         wday    <= '0;
         month   <= '0;
         century <= 1'b0;
         year    <= '0;
      end else if (commit) begin
         sec     <= shadow[0][6:0];
         vl      <= shadow[0][7];
         min     <= shadow[1][6:0];
         hour    <= shadow[2][5:0];
         day     <= shadow[3][5:0];
         wday    <= shadow[4][2:0];
         month   <= shadow[5][4:0];
         century <= shadow[5][7];
         year    <= if_rdata;
      end
   end

   // Snapshot strobe and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         snap_valid <= commit;
         if (commit)      timeout_err <= 1'b0;
         else if (expire) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pcf8563_poll_sched.sv
// Bench for pcf8563_poll_sched: behavioural read engine, snapshot scoreboard
// and one task per scenario.
`timescale 1ns/1ps
module tb_pcf8563_poll_sched;

   localparam int PERIOD  = 50;
   localparam int TIMEOUT = 20;

   typedef struct packed {
      logic [6:0] sec;
      logic [6:0] min;
      logic [5:0] hour;
      logic [5:0] day;
      logic [2:0] wday;
      logic [4:0] month;
      logic [7:0] year;
      logic       vl;
      logic       century;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       req;
   logic       if_start;
   logic [7:0] if_rdata;
   logic       if_done;
   logic [6:0] sec;
   logic [6:0] min;
   logic [5:0] hour;
   logic [5:0] day;
   logic [2:0] wday;
   logic [4:0] month;
   logic [7:0] year;
   logic       vl;
   logic       century;
   logic       snap_valid;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cnt = 0;
   int last_start_cyc = -1;
   int snap_cnt = 0;
   int last_snap_cyc = -1;
   int last_done_cyc = -1;

   logic [6:0][7:0] eng_bytes;
   int eng_n = 7;
   int eng_gap = 1;
   int eng_sent = 0;
   bit eng_busy = 1'b0;

   snap_t exp_q[$];
   snap_t last_exp;
   snap_t mon_exp;
   snap_t mon_cur;

   pcf8563_poll_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .if_start(if_start), .if_rdata(if_rdata), .if_done(if_done),
      .sec(sec), .min(min), .hour(hour), .day(day), .wday(wday),
      .month(month), .year(year), .vl(vl), .century(century),
      .snap_valid(snap_valid), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic snap_t model_snap(input logic [6:0][7:0] b);
      snap_t m;
      m.sec     = b[0][6:0];
      m.vl      = b[0][7];
      m.min     = b[1][6:0];
      m.hour    = b[2][5:0];
      m.day     = b[3][5:0];
      m.wday    = b[4][2:0];
      m.month   = b[5][4:0];
      m.century = b[5][7];
      m.year    = b[6];
      return m;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.sec = sec; s.min = min; s.hour = hour; s.day = day; s.wday = wday;
      s.month = month; s.year = year; s.vl = vl; s.century = century;
      return s;
   endfunction

   // Monitor: counts starts, pops the scoreboard on each snapshot.
   always @(negedge clk) begin
      if (if_start === 1'b1) begin
         start_cnt++;
         last_start_cyc = cyc;
      end
      if (snap_valid === 1'b1) begin
         snap_cnt++;
         last_snap_cyc = cyc;
         mon_cur = dut_snap();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL snap_unexpected got=%h at cyc %0d", mon_cur, cyc);
         end else begin
            mon_exp  = exp_q.pop_front();
            last_exp = mon_exp;
            if (mon_cur !== mon_exp) begin
               errors++;
               $display("FAIL snap_data got=%h exp=%h", mon_cur, mon_exp);
            end
         end
         checks++;
         if (cyc !== last_done_cyc + 1) begin
            errors++;
            $display("FAIL snap_latency got cyc %0d exp %0d", cyc, last_done_cyc + 1);
         end
      end
   end

   // Behavioural read engine: answers each start with eng_n bytes.
   initial begin
      if_done  = 1'b0;
      if_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (if_start === 1'b1 && rst_n === 1'b1) begin
            eng_busy = 1'b1;
            eng_sent = 0;
            for (int b = 0; b < eng_n; b++) begin
               repeat (eng_gap) @(posedge clk);
               #1;
               if_done       = 1'b1;
               if_rdata      = eng_bytes[b];
               eng_sent      = b + 1;
               last_done_cyc = cyc;
               @(posedge clk);
               #1;
               if_done  = 1'b0;
               if_rdata = 8'h00;
            end
            eng_busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_req();
      next_cycle();
      req = 1'b1;
      next_cycle();
      req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; req = 1'b0; eng_bytes = '0;
      #3;
      checks++;
      if (dut_snap() !== '0) begin
         errors++; $display("FAIL reset_snapshot got=%h exp=0", dut_snap());
      end
      checks++;
      if ({if_start, busy, snap_valid, timeout_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=0000", {if_start, busy, snap_valid, timeout_err});
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();
      checks++;
      if (busy !== 1'b0 || if_start !== 1'b0) begin
         errors++; $display("FAIL reset_release busy=%b start=%b exp 0 0", busy, if_start);
      end
      last_exp = '0;
   endtask

   task automatic test_periodic();
      int t0, s0, n0, snap1;
      eng_bytes = {8'h24, 8'h92, 8'h06, 8'h31, 8'h23, 8'h59, 8'h85};
      eng_n = 7; eng_gap = 1;
      exp_q.push_back(model_snap(eng_bytes));
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt; n0 = snap_cnt;
      next_cycle();
      en = 1'b1; t0 = cyc;
      for (int i = 0; i < PERIOD + 20 && start_cnt == s0; i++) settle();
      checks++;
      if (start_cnt !== s0 + 1 || last_start_cyc !== t0 + PERIOD) begin
         errors++; $display("FAIL poll1_start got cyc %0d exp %0d", last_start_cyc, t0 + PERIOD);
      end
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      checks++;
      if (snap_cnt !== n0 + 1) begin
         errors++; $display("FAIL poll1_snap count=%0d exp %0d", snap_cnt, n0 + 1);
      end
      snap1 = last_snap_cyc;
      checks++;
      if (sec !== 7'h05 || vl !== 1'b1 || min !== 7'h59 || hour !== 6'h23 || day !== 6'h31 ||
          wday !== 3'd6 || month !== 5'h12 || century !== 1'b1 || year !== 8'h24) begin
         errors++; $display("FAIL poll1_fields got=%h", dut_snap());
      end
      for (int i = 0; i < PERIOD + 20 && start_cnt == s0 + 1; i++) settle();
      checks++;
      if (start_cnt !== s0 + 2 || last_start_cyc !== snap1 + 1 + PERIOD) begin
         errors++; $display("FAIL poll2_start got cyc %0d exp %0d", last_start_cyc, snap1 + 1 + PERIOD);
      end
      for (int i = 0; i < 100 && snap_cnt == n0 + 1; i++) settle();
      next_cycle();
      en = 1'b0;
      checks++;
      if (snap_cnt !== n0 + 2) begin
         errors++; $display("FAIL poll2_snap count=%0d exp %0d", snap_cnt, n0 + 2);
      end
   endtask

   task automatic test_on_demand();
      int r, s0, n0;
      eng_bytes = {8'h99, 8'h07, 8'h03, 8'h15, 8'h08, 8'h34, 8'h12};
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt; n0 = snap_cnt;
      next_cycle();
      en = 1'b1;
      repeat (10) next_cycle();
      req = 1'b1; r = cyc;
      next_cycle();
      req = 1'b0;
      for (int i = 0; i < 20 && start_cnt == s0; i++) settle();
      checks++;
      if (start_cnt !== s0 + 1 || last_start_cyc !== r + 2) begin
         errors++; $display("FAIL ondemand_start got cyc %0d exp %0d", last_start_cyc, r + 2);
      end
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      repeat (40) settle();
      checks++;
      if (snap_cnt !== n0 + 1 || start_cnt !== s0 + 1) begin
         errors++; $display("FAIL ondemand_once snaps=%0d starts=%0d exp %0d %0d",
                            snap_cnt - n0, start_cnt - s0, 1, 1);
      end
      next_cycle();
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int s0, n0, snap1;
      eng_bytes = {8'h25, 8'h11, 8'h02, 8'h09, 8'h14, 8'h47, 8'h30};
      exp_q.push_back(model_snap(eng_bytes));
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt; n0 = snap_cnt;
      next_cycle();
      en = 1'b1;
      pulse_req();
      for (int i = 0; i < 50 && eng_sent != 3; i++) settle();
      pulse_req();
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      snap1 = last_snap_cyc;
      for (int i = 0; i < 20 && start_cnt == s0 + 1; i++) settle();
      checks++;
      if (start_cnt !== s0 + 2 || last_start_cyc !== snap1 + 2) begin
         errors++; $display("FAIL b2b_start got cyc %0d exp %0d", last_start_cyc, snap1 + 2);
      end
      for (int i = 0; i < 100 && snap_cnt == n0 + 1; i++) settle();
      next_cycle();
      en = 1'b0;
      checks++;
      if (snap_cnt !== n0 + 2) begin
         errors++; $display("FAIL b2b_snaps count=%0d exp %0d", snap_cnt - n0, 2);
      end
   endtask

   task automatic test_slow_engine();
      int n0;
      eng_bytes = {8'h31, 8'h88, 8'h05, 8'h28, 8'h16, 8'h22, 8'h41};
      eng_gap = TIMEOUT - 1;
      exp_q.push_back(model_snap(eng_bytes));
      n0 = snap_cnt;
      next_cycle();
      en = 1'b1;
      pulse_req();
      for (int i = 0; i < 8 * TIMEOUT + 40 && snap_cnt == n0; i++) settle();
      checks++;
      if (snap_cnt !== n0 + 1 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL slow_engine snaps=%0d terr=%b exp 1 0", snap_cnt - n0, timeout_err);
      end
      next_cycle();
      en = 1'b0;
      eng_gap = 1;
   endtask

   task automatic test_timeout();
      int d3, n0, s0;
      eng_bytes = {8'h50, 8'h01, 8'h04, 8'h17, 8'h12, 8'h33, 8'h44};
      eng_n = 3;
      n0 = snap_cnt;
      next_cycle();
      en = 1'b1;
      pulse_req();
      for (int i = 0; i < 50 && eng_sent != 3; i++) settle();
      d3 = last_done_cyc;
      for (int i = 0; i < 40 && cyc < d3 + TIMEOUT; i++) settle();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_early terr=%b busy=%b exp 0 1", timeout_err, busy);
      end
      settle();
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_fire terr=%b busy=%b exp 1 0", timeout_err, busy);
      end
      checks++;
      if (dut_snap() !== last_exp || snap_cnt !== n0) begin
         errors++; $display("FAIL timeout_hold got=%h exp=%h", dut_snap(), last_exp);
      end
      eng_n = 7;
      eng_bytes = {8'h26, 8'h83, 8'h01, 8'h27, 8'h19, 8'h45, 8'h59};
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt;
      pulse_req();
      for (int i = 0; i < 20 && start_cnt == s0; i++) settle();
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky terr=%b busy=%b exp 1 1", timeout_err, busy);
      end
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      checks++;
      if (timeout_err !== 1'b0 || snap_cnt !== n0 + 1) begin
         errors++; $display("FAIL timeout_clear terr=%b snaps=%0d exp 0 1", timeout_err, snap_cnt - n0);
      end
      next_cycle();
      en = 1'b0;
   endtask

   task automatic test_abort();
      int e, n0, s0;
      eng_bytes = {8'h10, 8'h05, 8'h07, 8'h30, 8'h21, 8'h12, 8'h13};
      n0 = snap_cnt;
      next_cycle();
      en = 1'b1;
      pulse_req();
      for (int i = 0; i < 50 && eng_sent != 4; i++) settle();
      next_cycle();
      en = 1'b0;
      settle();
      settle();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_idle busy=%b exp 0", busy);
      end
      for (int i = 0; i < 50 && eng_busy; i++) settle();
      repeat (3) settle();
      checks++;
      if (dut_snap() !== last_exp || snap_cnt !== n0) begin
         errors++; $display("FAIL abort_hold got=%h exp=%h snaps=%0d", dut_snap(), last_exp, snap_cnt - n0);
      end
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt;
      next_cycle();
      en = 1'b1; e = cyc;
      for (int i = 0; i < PERIOD + 20 && start_cnt == s0; i++) settle();
      checks++;
      if (last_start_cyc !== e + PERIOD) begin
         errors++; $display("FAIL abort_resume got cyc %0d exp %0d", last_start_cyc, e + PERIOD);
      end
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      next_cycle();
      en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int r, s0, n0;
      eng_bytes = {8'h45, 8'h23, 8'h02, 8'h11, 8'h10, 8'h36, 8'h29};
      next_cycle();
      en = 1'b1;
      pulse_req();
      for (int i = 0; i < 50 && eng_sent != 2; i++) settle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_snap() !== '0 || {if_start, busy, snap_valid, timeout_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_async snap=%h ctrl=%b exp 0", dut_snap(),
                            {if_start, busy, snap_valid, timeout_err});
      end
      for (int i = 0; i < 50 && eng_busy; i++) settle();
      next_cycle();
      rst_n = 1'b1; r = cyc;
      last_exp = '0;
      eng_bytes = {7{8'hFF}};
      exp_q.push_back(model_snap(eng_bytes));
      s0 = start_cnt; n0 = snap_cnt;
      settle();
      checks++;
      if (busy !== 1'b0 || dut_snap() !== '0) begin
         errors++; $display("FAIL reset_after busy=%b snap=%h exp 0", busy, dut_snap());
      end
      for (int i = 0; i < PERIOD + 20 && start_cnt == s0; i++) settle();
      checks++;
      if (start_cnt !== s0 + 1 || last_start_cyc !== r + PERIOD) begin
         errors++; $display("FAIL reset_first_poll got cyc %0d exp %0d", last_start_cyc, r + PERIOD);
      end
      for (int i = 0; i < 100 && snap_cnt == n0; i++) settle();
      checks++;
      if (sec !== 7'h7F || vl !== 1'b1 || hour !== 6'h3F || day !== 6'h3F ||
          wday !== 3'h7 || month !== 5'h1F || century !== 1'b1 || year !== 8'hFF) begin
         errors++; $display("FAIL mask_fields got=%h", dut_snap());
      end
      next_cycle();
      en = 1'b0;
   endtask

   task automatic test_drain();
      repeat (5) settle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_on_demand();
      test_back_to_back();
      test_slow_engine();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
